// File: rtl/multicore_system_mul_arbiter.sv
// Round-robin arbiter sharing one 16x16 partial-product multiplier cell among NUM_REQ requesters.
// Optional: define MULT_ARB_ZERO_BYPASS_EN to answer zero-operand requests without using the cell.
module multicore_system_mul_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*32-1:0]   req_src1,
    input  logic [NUM_REQ*32-1:0]   req_src2,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    busy,
    output logic [31:0]             mul_src1,
    output logic [31:0]             mul_src2,
    output logic                    mul_en,
    input  logic [31:0]             mul_p1,
    input  logic [31:0]             mul_p2,
    input  logic [31:0]             mul_p3
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_COMBINE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_id;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mul_en;
    logic                r_rsp_valid;
    logic                r_busy;
    logic [ID_W-1:0]     r_rsp_id;
    logic [31:0]         r_rsp_result;
    logic [31:0]         r_mul_src1;
    logic [31:0]         r_mul_src2;

    logic                w_mul_en_nxt;
    logic                w_rsp_valid_nxt;
    logic                w_busy_nxt;
    logic                w_any;
    logic [NUM_REQ-1:0]  w_ptr_mask;
    logic [NUM_REQ-1:0]  w_masked;
    logic [NUM_REQ-1:0]  w_pick;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [ID_W-1:0]     w_id;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [31:0]         w_op1;
    logic [31:0]         w_op2;
    logic [15:0]         w_mid_sum;
    logic [31:0]         w_product;
    logic                w_unused_hi;

    logic [NUM_REQ:0][ID_W-1:0] w_id_acc;
    logic [NUM_REQ:0][31:0]     w_op1_acc;
    logic [NUM_REQ:0][31:0]     w_op2_acc;

    // Round-robin pick: lowest request at/after the pointer, else lowest overall (wrap)
    assign w_any    = |req_valid;
    assign w_masked = req_valid & w_ptr_mask;
    assign w_pick   = (|w_masked) ? w_masked : req_valid;
    assign w_onehot = w_pick & (~w_pick + NUM_REQ'(1));

    assign w_id_acc[0]  = '0;
    assign w_op1_acc[0] = '0;
    assign w_op2_acc[0] = '0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign w_ptr_mask[g]   = (ID_W'(g) >= r_ptr);
        assign w_id_acc[g+1]   = w_id_acc[g]  | (w_onehot[g] ? ID_W'(g) : '0);
        assign w_op1_acc[g+1]  = w_op1_acc[g] | (w_onehot[g] ? req_src1[32*g +: 32] : 32'h0);
        assign w_op2_acc[g+1]  = w_op2_acc[g] | (w_onehot[g] ? req_src2[32*g +: 32] : 32'h0);
    end

    assign w_id      = w_id_acc[NUM_REQ];
    assign w_op1     = w_op1_acc[NUM_REQ];
    assign w_op2     = w_op2_acc[NUM_REQ];
    assign w_ptr_nxt = (w_id == ID_W'(NUM_REQ - 1)) ? '0 : w_id + ID_W'(1);

    // Only the low 16 bits of p2+p3 land inside the 32-bit product
    assign w_mid_sum   = mul_p2[15:0] + mul_p3[15:0];
    assign w_product   = mul_p1 + {w_mid_sum, 16'h0000};
    assign w_unused_hi = ^{mul_p2[31:16], mul_p3[31:16]};

`ifdef MULT_ARB_ZERO_BYPASS_EN
    logic w_zero;
    assign w_zero = (w_op1 == 32'h0) || (w_op2 == 32'h0);
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
`ifdef MULT_ARB_ZERO_BYPASS_EN
                    w_state_nxt = w_zero ? S_RESP : S_ISSUE;
`else
                    w_state_nxt = S_ISSUE;
`endif
                end
            end
            S_ISSUE:   if (r_cnt == '0) w_state_nxt = S_COMBINE;
            S_COMBINE: w_state_nxt = S_RESP;
            S_RESP:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    // Grant is combinational in IDLE; other outputs are registered from the next state
    always_comb begin
        req_grant       = '0;
        w_mul_en_nxt    = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        if (r_state == S_IDLE) req_grant = w_onehot;
        w_mul_en_nxt    = (w_state_nxt == S_ISSUE);
        w_rsp_valid_nxt = (w_state_nxt == S_RESP);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            r_id         <= '0;
            r_cnt        <= '0;
            r_mul_en     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_mul_src1   <= '0;
            r_mul_src2   <= '0;
        end else begin
            r_mul_en    <= w_mul_en_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_busy      <= w_busy_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_id  <= w_id;
                        r_ptr <= w_ptr_nxt;
                        r_cnt <= CNT_W'(MUL_LAT - 1);
`ifdef MULT_ARB_ZERO_BYPASS_EN
                        if (w_zero) begin
                            r_rsp_result <= '0;
                            r_rsp_id     <= w_id;
                        end else begin
                            r_mul_src1 <= w_op1;
                            r_mul_src2 <= w_op2;
                        end
`else
                        r_mul_src1 <= w_op1;
                        r_mul_src2 <= w_op2;
`endif
                    end
                end
                S_ISSUE: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
                end
                S_COMBINE: begin
                    r_rsp_result <= w_product;
                    r_rsp_id     <= r_id;
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign busy       = r_busy;
    assign mul_src1   = r_mul_src1;
    assign mul_src2   = r_mul_src2;
    assign mul_en     = r_mul_en;

endmodule

// File: tb/tb_multicore_system_mul_arbiter.sv
// Directed bench for multicore_system_mul_arbiter: MUL_LAT=1 and MUL_LAT=3 instances, each with a cell model.
module tb_multicore_system_mul_arbiter;

    logic         clk;
    logic         reset;

    logic [3:0]   req_valid;
    logic [127:0] req_src1, req_src2;
    logic [3:0]   req_grant;
    logic         rsp_valid, busy, mul_en;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_result, mul_src1, mul_src2, mul_p1, mul_p2, mul_p3;

    logic [3:0]   r3_valid;
    logic [127:0] r3_src1, r3_src2;
    logic [3:0]   r3_grant;
    logic         r3_rsp_valid, r3_busy, r3_mul_en;
    logic [1:0]   r3_rsp_id;
    logic [31:0]  r3_result, r3_src1_o, r3_src2_o, r3_p1, r3_p2, r3_p3;

    int n_cmp = 0;
    int n_err = 0;

    multicore_system_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_src1(req_src1), .req_src2(req_src2),
        .req_grant(req_grant), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .busy(busy), .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_en(mul_en),
        .mul_p1(mul_p1), .mul_p2(mul_p2), .mul_p3(mul_p3)
    );

    multicore_system_mul_arbiter #(.NUM_REQ(4), .ID_W(2), .MUL_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(r3_valid), .req_src1(r3_src1), .req_src2(r3_src2),
        .req_grant(r3_grant), .rsp_valid(r3_rsp_valid), .rsp_id(r3_rsp_id), .rsp_result(r3_result),
        .busy(r3_busy), .mul_src1(r3_src1_o), .mul_src2(r3_src2_o), .mul_en(r3_mul_en),
        .mul_p1(r3_p1), .mul_p2(r3_p2), .mul_p3(r3_p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] pp(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p1, p2, p3;
        p1 = {16'h0, a[15:0]}  * {16'h0, b[15:0]};
        p2 = {16'h0, a[15:0]}  * {16'h0, b[31:16]};
        p3 = {16'h0, a[31:16]} * {16'h0, b[15:0]};
        return {p1, p2, p3};
    endfunction

    // Cell models: a MUL_LAT-deep pipeline advancing only while mul_en is high
    logic [95:0] c1_q;
    logic [95:0] c3_q [3];
    initial c1_q = '0;
    initial begin
        for (int i = 0; i < 3; i++) c3_q[i] = '0;
    end
    always @(posedge clk) if (mul_en) c1_q <= pp(mul_src1, mul_src2);
    always @(posedge clk) begin
        if (r3_mul_en) begin
            c3_q[0] <= pp(r3_src1_o, r3_src2_o);
            c3_q[1] <= c3_q[0];
            c3_q[2] <= c3_q[1];
        end
    end
    assign {mul_p1, mul_p2, mul_p3} = c1_q;
    assign {r3_p1, r3_p2, r3_p3}    = c3_q[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Full-path operation on the MUL_LAT=1 instance, starting in an IDLE cycle (T)
    task automatic run_op(input logic [3:0] mask, input int idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        req_src1[idx*32 +: 32] = a;
        req_src2[idx*32 +: 32] = b;
        req_valid = mask;
        #1;
        check("grant_T", 32'(req_grant), 32'(1 << idx));
        check("busy_T", 32'(busy), 32'd0);
        step;
        req_valid = '0;
        check("mul_en_T1", 32'(mul_en), 32'd1);
        check("mul_src1_T1", mul_src1, a);
        check("mul_src2_T1", mul_src2, b);
        step;
        check("mul_en_T2", 32'(mul_en), 32'd0);
        check("rsp_valid_T2", 32'(rsp_valid), 32'd0);
        step;
        check("rsp_valid_T3", 32'(rsp_valid), 32'd1);
        check("rsp_id_T3", 32'(rsp_id), 32'(idx));
        check("rsp_result_T3", rsp_result, exp);
        step;
        check("rsp_valid_T4", 32'(rsp_valid), 32'd0);
        check("busy_T4", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0; req_src1 = '0; req_src2 = '0;
        r3_valid = '0;  r3_src1 = '0;  r3_src2 = '0;
        step; step;

        check("rst_grant", 32'(req_grant), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mul_en", 32'(mul_en), 32'd0);
        check("rst_mul_src1", mul_src1, 32'd0);
        check("rst_mul_src2", mul_src2, 32'd0);
        reset = 1'b0;

        // Basic op, full-width wrap, and p2+p3 carry truncation
        run_op(4'b0001, 0, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500);
        run_op(4'b0100, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op(4'b0100, 2, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000);

        // All four requesting continuously from reset: 0,1,2,3,0 every 4 cycles
        reset = 1'b1;
        step;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_src1[i*32 +: 32] = 32'(i + 1);
            req_src2[i*32 +: 32] = 32'h0000_0100;
        end
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_grant", 32'(req_grant), 32'(1 << (k % 4)));
            step;
            check("rr_busy_grant1", 32'(req_grant), 32'd0);
            check("rr_busy1", 32'(busy), 32'd1);
            step;
            check("rr_busy_grant2", 32'(req_grant), 32'd0);
            step;
            check("rr_busy_grant3", 32'(req_grant), 32'd0);
            check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            check("rr_rsp_id", 32'(rsp_id), 32'(k % 4));
            check("rr_rsp_result", rsp_result, 32'(((k % 4) + 1) * 256));
            step;
        end
        req_valid = '0;

        // Reset during ISSUE of req1 aborts the operation
        req_src1[32 +: 32] = 32'h0000_0055;
        req_src2[32 +: 32] = 32'h0000_0003;
        req_valid = 4'b0010;
        #1;
        check("abort_grant", 32'(req_grant), 32'h2);
        step;
        check("abort_issue", 32'(mul_en), 32'd1);
        reset = 1'b1;
        req_valid = '0;
        step;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_mul_en", 32'(mul_en), 32'd0);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_rsp_result", rsp_result, 32'd0);
        check("abort_mul_src1", mul_src1, 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        // Pointer back at 0: req1 beats req3
        run_op(4'b1010, 1, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340);
        run_op(4'b1000, 3, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001);

        // Zero operand
`ifdef MULT_ARB_ZERO_BYPASS_EN
        req_src1[31:0] = 32'h0;
        req_src2[31:0] = 32'h0000_1234;
        req_valid = 4'b0001;
        #1;
        check("zb_grant", 32'(req_grant), 32'h1);
        step;
        req_valid = '0;
        check("zb_rsp_valid", 32'(rsp_valid), 32'd1);
        check("zb_mul_en", 32'(mul_en), 32'd0);
        check("zb_rsp_result", rsp_result, 32'd0);
        check("zb_rsp_id", 32'(rsp_id), 32'd0);
        check("zb_mul_src1_held", mul_src1, 32'h0001_0001);
        step;
        check("zb_rsp_done", 32'(rsp_valid), 32'd0);
        check("zb_busy_done", 32'(busy), 32'd0);
`else
        run_op(4'b0001, 0, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000);
`endif

        // MUL_LAT=3 instance: enable held three cycles, response at T+5
        r3_src1[31:0] = 32'h0000_0007;
        r3_src2[31:0] = 32'h0000_0006;
        r3_valid = 4'b0001;
        #1;
        check("l3_grant", 32'(r3_grant), 32'h1);
        for (int c = 1; c <= 3; c++) begin
            step;
            r3_valid = '0;
            check("l3_mul_en_on", 32'(r3_mul_en), 32'd1);
        end
        step;
        check("l3_mul_en_off", 32'(r3_mul_en), 32'd0);
        check("l3_rsp_early", 32'(r3_rsp_valid), 32'd0);
        step;
        check("l3_rsp_valid", 32'(r3_rsp_valid), 32'd1);
        check("l3_rsp_id", 32'(r3_rsp_id), 32'd0);
        check("l3_rsp_result", r3_result, 32'h0000_002A);
        step;
        check("l3_rsp_done", 32'(r3_rsp_valid), 32'd0);
        check("l3_busy_done", 32'(r3_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
